// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage: credit-limited in-order imem requests feeding a DEPTH-entry prefetch queue toward decode.
// Optional macro FETCH_PERF_CNT_EN adds flush/stall performance counters.
module fetch_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hazard,
    input  logic                     branch_taken,
    input  logic [ADDR_W-1:0]        branch_address,
    output logic                     imem_req_valid,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [INSTR_W-1:0]       imem_rsp_data,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instruction,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_flush_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  q_pc   [DEPTH];
    logic [INSTR_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]   q_head, q_tail;
    logic [CNT_W-1:0]   count;
    logic [ADDR_W-1:0]  f_pc   [DEPTH];
    logic [PTR_W-1:0]   f_head, f_tail;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   discard_cnt;
    logic [0:0]         state;

    logic               credit_ok, accept, drop_rsp, push, pop;
    logic [PTR_W-1:0]   next_head;
    logic [CNT_W-1:0]   count_next, flush_outstanding;
    logic [ADDR_W-1:0]  head_pc_next;
    logic [INSTR_W-1:0] head_data_next;

    // Credit counts queued plus in-flight words so a returning response always has a free slot.
    assign credit_ok         = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
    assign imem_req_valid    = rst & ~branch_taken & credit_ok;
    assign imem_req_addr     = fetch_pc;
    assign accept            = imem_req_valid & imem_req_ready;
    assign drop_rsp          = imem_rsp_valid & (branch_taken | (state == ST_DRAIN));
    assign push              = imem_rsp_valid & ~drop_rsp;
    assign out_valid         = (count != '0);
    assign pop               = out_valid & ~hazard & ~branch_taken;
    assign q_count           = count;
    assign next_head         = q_head + PTR_W'(pop);
    assign count_next        = count + CNT_W'(push) - CNT_W'(pop);
    assign flush_outstanding = outstanding - CNT_W'(imem_rsp_valid);

    // The word landing this edge becomes the head only when the queue drains down to it.
    always_comb begin
        head_pc_next   = q_pc[next_head];
        head_data_next = q_data[next_head];
        if (push && (next_head == q_tail)) begin
            head_pc_next   = f_pc[f_head];
            head_data_next = imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            f_pc[f_tail] <= fetch_pc;
        if (push) begin
            q_pc[q_tail]   <= f_pc[f_head];
            q_data[q_tail] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc        <= RESET_PC;
            q_head          <= '0;
            q_tail          <= '0;
            count           <= '0;
            f_head          <= '0;
            f_tail          <= '0;
            outstanding     <= '0;
            discard_cnt     <= '0;
            state           <= ST_RUN;
            out_pc          <= '0;
            out_instruction <= '0;
        end else if (branch_taken) begin
            // Everything still in flight belongs to the old path and must be dropped on return.
            fetch_pc    <= branch_address;
            q_head      <= '0;
            q_tail      <= '0;
            count       <= '0;
            f_head      <= '0;
            f_tail      <= '0;
            outstanding <= flush_outstanding;
            discard_cnt <= flush_outstanding;
            state       <= (flush_outstanding != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                f_tail   <= f_tail + 1'b1;
            end
            if (push) begin
                q_tail <= q_tail + 1'b1;
                f_head <= f_head + 1'b1;
            end
            q_head      <= next_head;
            count       <= count_next;
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
            if (drop_rsp) begin
                discard_cnt <= discard_cnt - 1'b1;
                state       <= (discard_cnt == CNT_W'(1)) ? ST_RUN : ST_DRAIN;
            end
            if (count_next != '0) begin
                out_pc          <= head_pc_next;
                out_instruction <= head_data_next;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (branch_taken)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            if (out_valid && hazard)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomized bench for fetch_prefetch_queue: an in-order latency memory plus a queue-level reference model.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard, branch_taken, imem_req_ready, imem_rsp_valid;
    logic [31:0] branch_address, imem_rsp_data;
    logic        imem_req_valid, out_valid;
    logic [31:0] imem_req_addr, out_pc, out_instruction;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    fetch_prefetch_queue dut (
        .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
        .q_count(q_count)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    entry_t  mq[$];
    flight_t infl[$];
    mem_t    mem_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    logic [31:0] m_pc, last_pc, last_instr;
    int          p_hazard, p_branch, p_ready, max_lat;

    // Per-phase stimulus mix: sequential streaming, long stalls, redirects under latency, memory backpressure.
    int ph_haz [8] = '{0, 90, 20, 10, 50, 30, 0, 60};
    int ph_br  [8] = '{0, 0, 8, 0, 20, 5, 10, 3};
    int ph_rdy [8] = '{100, 100, 100, 0, 80, 60, 100, 90};
    int ph_lat [8] = '{1, 1, 3, 2, 1, 4, 3, 2};
    int ph_len [8] = '{40, 60, 200, 12, 200, 200, 150, 200};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        infl.delete();
        mem_q.delete();
        m_pc       = 32'h0;
        last_pc    = 32'h0;
        last_instr = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        hazard         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        model_reset();
        #1;
        check_output("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check_output("rst_out_valid", 32'(out_valid), 32'h0);
        check_output("rst_out_pc", out_pc, 32'h0);
        check_output("rst_out_instr", out_instruction, 32'h0);
        check_output("rst_q_count", 32'(q_count), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic apply_stimulus();
        cycle++;
        hazard         = ($urandom_range(0, 99) < p_hazard);
        branch_taken   = ($urandom_range(0, 99) < p_branch);
        branch_address = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {20'h0, $urandom_range(0, 1023), 2'b00};
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic step_model();
        bit      exp_rv;
        flight_t f;
        exp_rv = !branch_taken && ((mq.size() + infl.size()) < 4);
        check_output("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv)
            check_output("req_addr", imem_req_addr, m_pc);
        check_output("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            last_pc    = mq[0].pc;
            last_instr = mq[0].data;
        end
        check_output("out_pc", out_pc, last_pc);
        check_output("out_instr", out_instruction, last_instr);
        check_output("q_count", 32'(q_count), 32'(mq.size()));

        f.addr  = 32'h0;
        f.stale = 1'b1;
        if (imem_rsp_valid) begin
            f = infl.pop_front();
            void'(mem_q.pop_front());
        end
        if (branch_taken) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_pc = branch_address;
        end else begin
            if (mq.size() > 0 && !hazard)
                void'(mq.pop_front());
            if (imem_rsp_valid && !f.stale)
                mq.push_back('{pc: f.addr, data: mem_word(f.addr)});
            if (exp_rv && imem_req_ready) begin
                infl.push_back('{addr: m_pc, stale: 1'b0});
                mem_q.push_back('{addr: m_pc, due: cycle + $urandom_range(1, max_lat)});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            p_hazard = ph_haz[ph];
            p_branch = ph_br[ph];
            p_ready  = ph_rdy[ph];
            max_lat  = ph_lat[ph];
            if (ph == 6)
                do_reset();
            for (int c = 0; c < ph_len[ph]; c++) begin
                @(posedge clk);
                #1;
                apply_stimulus();
                @(negedge clk);
                step_model();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
